// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Bridges the pipeline MEM stage to the data memory. A CPU load or store
// (byte/half/word/dword, signed or unsigned) becomes a single aligned 64-bit
// access with a byte mask. Memory-side signals stay constant until
// access_done. The pipeline is stalled for the whole access, and load data
// is shifted down and zero- or sign-extended into the register-file value.
//
// Optional feature: define MEM_CTRL_PERF_EN to build the saturating
// performance counters perf_accesses and perf_stall_cycles. When it is not
// defined, both ports are tied to zero and no counter registers exist.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid           MEM stage presents a request
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_size            00 byte, 01 half, 10 word, 11 dword
//   req_signed          sign-extend the load result
//   req_wdata           store data, right-justified
//   stall               freeze the pipeline
//   resp_valid          one-cycle pulse when an access completes
//   resp_rdata          extended load data (holds until the next load)
//   misalign_err        one-cycle pulse when a request is rejected
//   address             aligned memory address (low 3 bits zero)
//   data_in             store data placed on its byte lanes
//   bytemask            byte enables
//   write               memory write strobe
//   start_access        memory access request
//   access_done         memory access finished
//   data_out            memory read data (valid while access_done = 1)
//   perf_accesses       completed-access counter (optional)
//   perf_stall_cycles   stall-cycle counter (optional)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [63:0]           req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  misalign_err,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [63:0]           data_in,
    output logic [7:0]            bytemask,
    output logic                  write,
    output logic                  start_access,
    input  logic                  access_done,
    input  logic [63:0]           data_out,
    output logic [31:0]           perf_accesses,
    output logic [31:0]           perf_stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [63:0]           r_data_in;
    logic [7:0]            r_bytemask;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [2:0]            r_lane;
    logic [63:0]           r_resp_rdata;

    logic [2:0]            w_lane;
    logic [2:0]            w_size_lsbs;
    logic                  w_misaligned;
    logic                  w_accept;
    logic [7:0]            w_bytemask;
    logic [63:0]           w_data_in;
    logic [63:0]           w_rd_shifted;
    logic                  w_stall;

    // Low-bit mask of an access of the given size (nbytes - 1).
    function automatic logic [2:0] size_lsbs(input logic [1:0] size);
        case (size)
            2'd0:    size_lsbs = 3'b000;
            2'd1:    size_lsbs = 3'b001;
            2'd2:    size_lsbs = 3'b011;
            default: size_lsbs = 3'b111;
        endcase
    endfunction

    // Byte enables of an access of the given size before lane placement.
    function automatic logic [7:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 8'h01;
            2'd1:    size_bytes = 8'h03;
            2'd2:    size_bytes = 8'h0F;
            default: size_bytes = 8'hFF;
        endcase
    endfunction

    // Truncate the lane-shifted read data to the access size and extend it.
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        case (size)
            2'd0:    extend_load = {{56{sgn & raw[7]}},  raw[7:0]};
            2'd1:    extend_load = {{48{sgn & raw[15]}}, raw[15:0]};
            2'd2:    extend_load = {{32{sgn & raw[31]}}, raw[31:0]};
            default: extend_load = raw;
        endcase
    endfunction

    assign w_lane       = req_addr[2:0];
    assign w_size_lsbs  = size_lsbs(req_size);
    // lane mod nbytes != 0 reduces to any lane bit below the size boundary.
    assign w_misaligned = |(w_lane & w_size_lsbs);
    assign w_accept     = (r_state == ST_IDLE) && req_valid && !w_misaligned;
    assign w_bytemask   = size_bytes(req_size) << w_lane;
    assign w_data_in    = req_wdata << {w_lane, 3'b000};
    assign w_rd_shifted = data_out >> {r_lane, 3'b000};
    assign w_stall      = w_accept || (r_state == ST_BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_data_in    <= '0;
            r_bytemask   <= '0;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_lane       <= 3'd0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_address  <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
                        r_data_in  <= w_data_in;
                        r_bytemask <= w_bytemask;
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_lane     <= w_lane;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (access_done) begin
                        // Stores leave the previous load result in place.
                        if (!r_write) begin
                            r_resp_rdata <= extend_load(w_rd_shifted, r_size, r_signed);
                        end
                        r_state <= ST_RESP;
                    end
                end
                // Requests presented during the response cycle are not taken;
                // the pipeline advances at this edge and re-presents from IDLE.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall        = w_stall;
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_rdata   = r_resp_rdata;
    assign misalign_err = (r_state == ST_IDLE) && req_valid && w_misaligned;
    assign address      = r_address;
    assign data_in      = r_data_in;
    assign bytemask     = r_bytemask;
    assign write        = r_write;
    // Dropped in the done cycle so the memory never sees a back-to-back start.
    assign start_access = (r_state == ST_BUSY) && !access_done;

`ifdef MEM_CTRL_PERF_EN
    logic [31:0] r_perf_accesses;
    logic [31:0] r_perf_stall_cycles;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        sat_inc = (&val) ? val : val + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_accesses     <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if ((r_state == ST_BUSY) && access_done) begin
                r_perf_accesses <= sat_inc(r_perf_accesses);
            end
            if (w_stall) begin
                r_perf_stall_cycles <= sat_inc(r_perf_stall_cycles);
            end
        end
    end

    assign perf_accesses     = r_perf_accesses;
    assign perf_stall_cycles = r_perf_stall_cycles;
`else
    assign perf_accesses     = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

    a_aligned_start: assert property (@(posedge clk) disable iff (reset)
        start_access |-> (address[2:0] == 3'b000));

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [19:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        misalign_err;
    logic [19:0] address;
    logic [63:0] data_in;
    logic [7:0]  bytemask;
    logic        write;
    logic        start_access;
    logic        access_done;
    logic [63:0] data_out;
    logic [31:0] perf_accesses;
    logic [31:0] perf_stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory behind the DUT (word array) and the reference byte image.
    logic [63:0] wmem    [0:15];
    logic [7:0]  ref_mem [0:127];
    logic [63:0] last_load;
    int          exp_acc;
    int          exp_stall;

    mem_access_ctrl #(.ADDR_WIDTH(20)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .req_signed        (req_signed),
        .req_wdata         (req_wdata),
        .stall             (stall),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .misalign_err      (misalign_err),
        .address           (address),
        .data_in           (data_in),
        .bytemask          (bytemask),
        .write             (write),
        .start_access      (start_access),
        .access_done       (access_done),
        .data_out          (data_out),
        .perf_accesses     (perf_accesses),
        .perf_stall_cycles (perf_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        wmem[idx] = val;
        for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = val[8*b +: 8];
    endtask

    // Expected load result straight from the byte image and the size/sign rules.
    function automatic logic [63:0] ref_load(input logic [19:0] addr, input int nbytes,
                                             input logic sgn);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nbytes; k++) v[8*k +: 8] = ref_mem[int'(addr[6:0]) + k];
        if (sgn && v[8*nbytes-1]) begin
            for (int k = nbytes; k < 8; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic do_access(input logic wr, input logic [19:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [63:0] wdata, input int lat);
        int          nbytes;
        int          lane;
        int          starts;
        logic [7:0]  exp_mask;
        logic [63:0] exp_din;
        logic [19:0] exp_addr;
        logic [63:0] wv;
        nbytes = 1 << size;
        lane   = int'(addr[2:0]);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        #1;
        if ((lane % nbytes) != 0) begin
            check("misalign_err_hi", 64'(misalign_err), 64'd1);
            check("misalign_stall", 64'(stall), 64'd0);
            check("misalign_start", 64'(start_access), 64'd0);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check("misalign_err_lo", 64'(misalign_err), 64'd0);
            check("misalign_idle_start", 64'(start_access), 64'd0);
            check("misalign_idle_stall", 64'(stall), 64'd0);
            check("misalign_no_resp", 64'(resp_valid), 64'd0);
            return;
        end
        check("accept_no_err", 64'(misalign_err), 64'd0);
        check("accept_stall", 64'(stall), 64'd1);
        exp_addr = addr & 20'hFFFF8;
        exp_mask = 8'(((1 << nbytes) - 1) << lane);
        exp_din  = '0;
        for (int b = lane; b < 8; b++) exp_din[8*b +: 8] = wdata[8*(b-lane) +: 8];
        exp_acc++;
        exp_stall += lat + 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom};
        starts = 0;
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            if (i == lat) begin
                access_done = 1'b1;
                data_out    = wmem[addr[6:3]];
            end else begin
                data_out    = {$urandom, $urandom};
            end
            #1;
            check("busy_start", 64'(start_access), 64'(i < lat));
            check("busy_stall", 64'(stall), 64'd1);
            check("busy_address", 64'(address), 64'(exp_addr));
            check("busy_bytemask", 64'(bytemask), 64'(exp_mask));
            check("busy_data_in", data_in, exp_din);
            check("busy_write", 64'(write), 64'(wr));
            check("busy_resp", 64'(resp_valid), 64'd0);
            if (start_access) starts++;
            if (i == lat && write) begin
                wv = wmem[address[6:3]];
                for (int b = 0; b < 8; b++) if (bytemask[b]) wv[8*b +: 8] = data_in[8*b +: 8];
                wmem[address[6:3]] = wv;
            end
            @(posedge clk);
        end
        check("start_burst_len", 64'(starts), 64'(lat - 1));
        @(negedge clk);
        access_done = 1'b0;
        data_out    = {$urandom, $urandom};
        if (wr) begin
            for (int k = 0; k < nbytes; k++) ref_mem[int'(addr[6:0]) + k] = wdata[8*k +: 8];
        end else begin
            last_load = ref_load(addr, nbytes, sgn);
        end
        #1;
        check("resp_valid_hi", 64'(resp_valid), 64'd1);
        check("resp_stall", 64'(stall), 64'd0);
        check("resp_start", 64'(start_access), 64'd0);
        check("resp_rdata", resp_rdata, last_load);
        @(posedge clk);
        #1;
        check("resp_valid_lo", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [1:0]  rsize;
        logic [19:0] raddr;
        int          rlane;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'd0;
        req_signed = 1'b0; req_wdata = '0; access_done = 1'b0; data_out = '0;
        last_load = '0; exp_acc = 0; exp_stall = 0;
        for (int i = 0; i < 16; i++) preload(i, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_start", 64'(start_access), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_bytemask", 64'(bytemask), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_perf_acc", 64'(perf_accesses), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed: dword store, byte store, byte loads.
        do_access(1'b1, 20'h00040, 2'd3, 1'b0, 64'h1122334455667788, 3);
        do_access(1'b1, 20'h00043, 2'd0, 1'b0, 64'h00000000000000AB, 2);
        preload(8, 64'h0000850000000000);
        do_access(1'b0, 20'h00045, 2'd0, 1'b1, 64'd0, 2);
        check("byte_load_signed", resp_rdata, 64'hFFFFFFFFFFFFFF85);
        do_access(1'b0, 20'h00045, 2'd0, 1'b0, 64'd0, 4);
        check("byte_load_unsigned", resp_rdata, 64'h0000000000000085);
        do_access(1'b0, 20'h00046, 2'd2, 1'b0, 64'd0, 2);
        check("rdata_held_after_misalign", resp_rdata, 64'h0000000000000085);

        // Reset two cycles into BUSY.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00010; req_size = 2'd2;
        req_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("busy1_start", 64'(start_access), 64'd1);
        @(negedge clk);
        #1;
        check("busy2_start", 64'(start_access), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_start", 64'(start_access), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_resp", 64'(resp_valid), 64'd0);
        check("midrst_bytemask", 64'(bytemask), 64'd0);
        check("midrst_address", 64'(address), 64'd0);
        check("midrst_rdata", resp_rdata, 64'd0);
        check("midrst_perf_stall", 64'(perf_stall_cycles), 64'd0);
        last_load = '0; exp_acc = 0; exp_stall = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_resp", 64'(resp_valid), 64'd0);
        check("postrst_start", 64'(start_access), 64'd0);

        // Half loads after reset.
        preload(0, 64'h00000000BEEF0000);
        do_access(1'b0, 20'h00002, 2'd1, 1'b0, 64'd0, 3);
        check("half_unsigned", resp_rdata, 64'h000000000000BEEF);
        do_access(1'b0, 20'h00002, 2'd1, 1'b1, 64'd0, 3);
        check("half_signed", resp_rdata, 64'hFFFFFFFFFFFFBEEF);
        do_access(1'b1, 20'h00008, 2'd2, 1'b0, 64'h00000000CAFEF00D, 3);
        check("store_keeps_rdata", resp_rdata, 64'hFFFFFFFFFFFFBEEF);

        // Randomized traffic, some of it misaligned.
        for (int n = 0; n < 80; n++) begin
            rsize = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rlane = $urandom_range(0, 7);
            else rlane = $urandom_range(0, (8 >> rsize) - 1) << rsize;
            raddr = 20'($urandom);
            raddr[2:0] = 3'(rlane);
            do_access(1'($urandom), raddr, rsize, 1'($urandom), {$urandom, $urandom},
                      $urandom_range(2, 5));
        end

`ifdef MEM_CTRL_PERF_EN
        check("perf_accesses", 64'(perf_accesses), 64'(exp_acc));
        check("perf_stall_cycles", 64'(perf_stall_cycles), 64'(exp_stall));
`else
        check("perf_accesses_tied", 64'(perf_accesses), 64'd0);
        check("perf_stall_tied", 64'(perf_stall_cycles), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
